// File: rtl/uart_cmd_rx.sv
// UART command receiver: 8N1, LSB first, stretched data-ready pulse for the command decoder.
// Optional even parity bit enabled by defining UART_CMD_RX_PARITY_EN.
module uart_cmd_rx #(
    parameter int CLK_DIV = 434,
    parameter int RDY_LEN = 8
) (
    input  logic       clk,
    input  logic       res,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       dout_rdy,
    output logic       frame_err,
`ifdef UART_CMD_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    // state  | meaning
    // IDLE   | line idle, waiting for a falling edge
    // START  | timing to the start-bit midpoint to reject glitches
    // DATA   | sampling the 8 data bits
    // PARITY | sampling the parity bit (parity builds only)
    // STOP   | sampling the stop bit, delivering the byte
    // BREAK  | stop bit was low; waiting for the line to return high

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int RDY_W = $clog2(RDY_LEN + 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_MID  = CNT_W'(CLK_DIV / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t           state, state_nxt;
    logic [1:0]       sync_q;
    logic             rxs;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [RDY_W-1:0] rdy_cnt;
    logic             at_mid, at_last, par_bad;

    assign rxs     = sync_q[1];
    assign at_mid  = (baud_cnt == BAUD_MID);
    assign at_last = (baud_cnt == BAUD_LAST);

`ifdef UART_CMD_RX_PARITY_EN
    logic par_q;
    assign par_bad = ^shreg ^ par_q;
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge res) begin
        if (res) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (!rxs) state_nxt = START;
            START:  if (at_mid) state_nxt = rxs ? IDLE : DATA;
            DATA: begin
                if (at_last && bit_cnt == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
            PARITY: if (at_last) state_nxt = STOP;
            STOP:   if (at_last) state_nxt = rxs ? IDLE : BREAK;
            BREAK:  if (rxs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        dout_rdy = (rdy_cnt != '0);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sync_q    <= 2'b11;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            dout      <= '0;
            rdy_cnt   <= '0;
            frame_err <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
            parity_err <= 1'b0;
            par_q      <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], rxd};
            frame_err <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // Restart the bit timer on every state change and at each bit boundary.
            if (state_nxt != state || at_last || state == IDLE || state == BREAK)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (rdy_cnt != '0)
                rdy_cnt <= rdy_cnt - 1'b1;

            case (state)
                START: if (at_mid) bit_cnt <= '0;
                DATA: begin
                    if (at_last) begin
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef UART_CMD_RX_PARITY_EN
                PARITY: if (at_last) par_q <= rxs;
`endif
                STOP: begin
                    if (at_last) begin
                        if (rxs && !par_bad) begin
                            dout    <= shreg;
                            rdy_cnt <= RDY_W'(RDY_LEN);
                        end
                        frame_err <= !rxs;
`ifdef UART_CMD_RX_PARITY_EN
                        parity_err <= par_bad;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at CLK_DIV=16, RDY_LEN=8.
// A negedge monitor records each dout_rdy pulse (byte, width, rise cycle) and error pulses.
module tb_uart_cmd_rx;

    localparam int CLK_DIV = 16;
    localparam int RDY_LEN = 8;
`ifdef UART_CMD_RX_PARITY_EN
    localparam int LAT = 2 + CLK_DIV/2 + 10*CLK_DIV + 1;
`else
    localparam int LAT = 2 + CLK_DIV/2 + 9*CLK_DIV + 1;
`endif

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] dout;
    logic       dout_rdy;
    logic       frame_err;
    logic       busy;
`ifdef UART_CMD_RX_PARITY_EN
    logic       parity_err;
    int         pe_cnt = 0;
`endif

    uart_cmd_rx #(.CLK_DIV(CLK_DIV), .RDY_LEN(RDY_LEN)) dut (
        .clk       (clk),
        .res       (res),
        .rxd       (rxd),
        .dout      (dout),
        .dout_rdy  (dout_rdy),
        .frame_err (frame_err),
`ifdef UART_CMD_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    logic [7:0] byte_q[$];
    int         width_q[$];
    int         rise_q[$];
    int         fe_cnt = 0;
    int         unstable = 0;
    int         rdy_w = 0;
    logic       rdy_prev = 1'b0;
    logic [7:0] hold_dout = 8'h00;
    int         start_cyc = 0;
    logic       last_par = 1'b0;

    always @(negedge clk) begin
        if (res) begin
            rdy_prev = 1'b0;
        end else begin
            if (dout_rdy && !rdy_prev) begin
                byte_q.push_back(dout);
                rise_q.push_back(cyc);
                hold_dout = dout;
                rdy_w = 0;
            end
            if (dout_rdy) begin
                rdy_w++;
                if (dout != hold_dout) unstable++;
            end
            if (!dout_rdy && rdy_prev) width_q.push_back(rdy_w);
            if (frame_err) fe_cnt++;
`ifdef UART_CMD_RX_PARITY_EN
            if (parity_err) pe_cnt++;
`endif
            rdy_prev = dout_rdy;
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        @(negedge clk);
        rxd = 1'b0;
        start_cyc = cyc;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (CLK_DIV) @(negedge clk);
        end
`ifdef UART_CMD_RX_PARITY_EN
        rxd = par;
        repeat (CLK_DIV) @(negedge clk);
`else
        last_par = par;
`endif
        rxd = stop;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_dout", dout, 8'h00);
        chk("reset_rdy", dout_rdy, 0);
        chk("reset_ferr", frame_err, 0);
        chk("reset_busy", busy, 0);
        res = 1'b0;
        idle(5);

        // single good byte
        send_frame(8'h41, 1'b1, 1'b0);
        chk("t1_busy_after_stop", busy, 0);
        chk("t1_rdy_in_frame_tail", dout_rdy, 1);
        chk("t1_dout_early", dout, 8'h41);
        idle(20);
        chk("t1_count", byte_q.size(), 1);
        chk("t1_byte", byte_q[0], 8'h41);
        chk("t1_width", width_q[0], RDY_LEN);
        chk("t1_latency", rise_q[0] - start_cyc, LAT);
        chk("t1_ferr", fe_cnt, 0);

        // back-to-back bytes
        send_frame(8'h7F, 1'b1, 1'b1);
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(30);
        chk("t2_count", byte_q.size(), 3);
        chk("t2_byte0", byte_q[1], 8'h7F);
        chk("t2_byte1", byte_q[2], 8'hC3);
        chk("t2_width0", width_q[1], RDY_LEN);
        chk("t2_width1", width_q[2], RDY_LEN);

        // framing error with line held low
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("t3_busy_break", busy, 1);
        chk("t3_ferr_pulse", fe_cnt, 1);
        chk("t3_dout_kept", dout, 8'hC3);
        chk("t3_no_rdy", byte_q.size(), 3);
        idle(5);
        chk("t3_busy_released", busy, 0);
        idle(30);
        chk("t3_no_spurious", byte_q.size(), 3);
        chk("t3_ferr_once", fe_cnt, 1);

        // short glitch on idle line
        @(negedge clk);
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_busy_in_start", busy, 1);
        idle(30);
        chk("t4_busy", busy, 0);
        chk("t4_no_rdy", byte_q.size(), 3);
        chk("t4_ferr", fe_cnt, 1);
        chk("t4_dout", dout, 8'hC3);

        // reset during D3 of 8'hA5
        @(negedge clk);
        rxd = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        rxd = 1'b1; repeat (CLK_DIV) @(negedge clk);
        rxd = 1'b0; repeat (CLK_DIV) @(negedge clk);
        rxd = 1'b1; repeat (CLK_DIV) @(negedge clk);
        rxd = 1'b0; repeat (CLK_DIV/2) @(negedge clk);
        res = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_dout_reset", dout, 8'h00);
        chk("t5_rdy_reset", dout_rdy, 0);
        chk("t5_busy_reset", busy, 0);
        res = 1'b0;
        idle(20);
        send_frame(8'h12, 1'b1, 1'b0);
        idle(30);
        chk("t5_count", byte_q.size(), 4);
        chk("t5_byte", byte_q[3], 8'h12);
        chk("t5_ferr", fe_cnt, 1);

`ifdef UART_CMD_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1);
        idle(30);
        chk("t6_perr_pulse", pe_cnt, 1);
        chk("t6_no_rdy", byte_q.size(), 4);
        chk("t6_dout_kept", dout, 8'h12);
        send_frame(8'h03, 1'b1, 1'b0);
        idle(30);
        chk("t6_perr_once", pe_cnt, 1);
        chk("t6_count", byte_q.size(), 5);
        chk("t6_byte", byte_q[4], 8'h03);
        chk("t6_width", width_q[4], RDY_LEN);
`endif

        chk("dout_stable_during_rdy", unstable, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
Serial UART receiver that turns the host link's RX line into command bytes for the command-decode unit. It sits directly upstream of the command decoder and drives that block's data byte and data-ready inputs. The data-ready output is a stretched level pulse, because the decoder edge-detects it through a multi-stage shift register. Format: 8 data bits, LSB first, 1 start bit, 1 stop bit, idle line high.

Parameters:
CLK_DIV, 434, clk cycles per bit (434 gives 115200 baud at 50 MHz); legal range 8..65535
RDY_LEN, 8, cycles dout_rdy is held high per good byte; legal range 4..(9*CLK_DIV-1)

Ports:
clk  in  1  system clock, rising edge
res  in  1  asynchronous active-high reset
rxd  in  1  asynchronous serial input, idle high
dout  out  8  last correctly received byte
dout_rdy  out  1  high for RDY_LEN cycles after each good byte
frame_err  out  1  one-cycle pulse when the stop bit is sampled low
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, res=1): FSM=IDLE; baud and bit counters=0; sync flops=1; dout=8'h00; dout_rdy=0; frame_err=0; busy=0.
- rxd passes through a 2-flop synchronizer (reset value 1). All logic below uses the synchronized value rxs.
- Baud counter width: $clog2(CLK_DIV). It counts 0..CLK_DIV-1 and reloads to 0 on each state entry.
- FSM states:
  - IDLE: on rxs==0, go to START and clear the baud counter.
  - START: when the counter reaches CLK_DIV/2-1 (integer divide), sample at the bit midpoint.
    - rxs==1: false start, go to IDLE; no outputs change.
    - rxs==0: go to DATA with bit counter=0.
  - DATA: sample every CLK_DIV cycles at the midpoint. Shift into the shift register LSB first (shreg <= {rxs, shreg[7:1]}). After the 8th sample, go to STOP.
  - STOP: after CLK_DIV cycles, sample at the midpoint.
    - rxs==1: dout <= shreg; load the RDY_LEN stretch counter; go to IDLE.
    - rxs==0: frame_err=1 for one cycle; dout is unchanged and dout_rdy is not asserted; go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE. This stops a held-low line from being re-read as a start bit.
- Latency: dout and dout_rdy update on the clk edge after the stop-bit midpoint sample. Counted from the start-bit falling edge at the rxd pin, this is 2 (sync) + CLK_DIV/2 + 9*CLK_DIV + 1 clocks.
- dout_rdy:
  - Driven from the stretch counter; high while the counter is nonzero.
  - Exactly RDY_LEN cycles wide.
  - dout is stable for the whole pulse.
  - A new start bit may be accepted while dout_rdy is still high. The next byte cannot complete within RDY_LEN cycles by the parameter constraint.
- Reset mid-frame: everything returns to the reset values immediately. A partial byte is discarded; no dout_rdy and no frame_err.
- Glitch shorter than CLK_DIV/2 on an idle line: rejected by the START midpoint check; no output activity.
- busy = (state != IDLE). It is high in BREAK and low during the dout_rdy stretch once the FSM is back in IDLE.

Optional Feature:
- Macro: UART_CMD_RX_PARITY_EN
- When defined:
  - Even parity bit follows D7. The PARITY state samples it CLK_DIV cycles after D7.
  - An extra output port parity_err (1 bit, reset 0) pulses one cycle at the stop sample if the XOR of the 8 data bits and the parity bit is 1.
  - On a parity error, dout is not updated and dout_rdy is not asserted.
  - Latency grows by CLK_DIV.
  - Combined parity and framing error: both pulses fire in the same cycle.
- When undefined: no PARITY state, no parity_err port; 10-bit frame.

Test Plan (CLK_DIV=16, RDY_LEN=8):
1. Send 8'h41 with a good stop bit -> dout=8'h41, dout_rdy high exactly 8 cycles, frame_err stays 0, busy low after the stop sample.
2. Send 8'h7F then 8'hC3 back to back with no idle gap -> two dout_rdy pulses with dout=8'h7F then 8'hC3; neither byte is lost.
3. Send 8'h55 with the stop bit driven low and the line held low 40 cycles -> one frame_err pulse, dout keeps its previous value, no dout_rdy, busy stays high until rxd returns high, and no spurious byte follows.
4. Drive a 5-cycle low glitch on an idle line -> FSM returns to IDLE, and dout, dout_rdy and frame_err are unchanged.
5. Assert res during bit D3 of 8'hA5, then release and send 8'h12 -> after reset dout=8'h00 and dout_rdy=0; the next byte reads 8'h12.
6. (UART_CMD_RX_PARITY_EN) Send 8'h03 with parity bit 1 -> parity_err pulses once and there is no dout_rdy. Send 8'h03 with parity bit 0 -> dout=8'h03 and dout_rdy is 8 cycles wide.
